// File: rtl/mem_wb_stage_if.sv
// Bus between the execute stage, the memory/write-back stage and the
// downstream consumers (forwarding/stall logic, register file).
interface mem_wb_stage_if;
   logic [31:0] exe_result;
   logic [31:0] exe_b;
   logic [4:0]  exe_rw;
   logic        exe_regwr;
   logic        exe_memwr;
   logic        exe_memtoreg;

   logic [31:0] mem_result;
   logic [4:0]  mem_rw;
   logic        mem_regwr;
   logic        mem_memtoreg;
   logic        mem_misalign;

   logic [4:0]  wb_rw;
   logic        wb_regwr;
   logic [31:0] wb_busw;

   modport master (
      output exe_result, exe_b, exe_rw, exe_regwr, exe_memwr, exe_memtoreg,
      input  mem_result, mem_rw, mem_regwr, mem_memtoreg, mem_misalign,
      input  wb_rw, wb_regwr, wb_busw
   );

   modport slave (
      input  exe_result, exe_b, exe_rw, exe_regwr, exe_memwr, exe_memtoreg,
      output mem_result, mem_rw, mem_regwr, mem_memtoreg, mem_misalign,
      output wb_rw, wb_regwr, wb_busw
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MIPS memory stage: EX/MEM register, word-addressed data memory and the
// MEM/WB register that produces the write-back bus.
module mem_wb_stage #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input logic           clk,
   input logic           rst,
   mem_wb_stage_if.slave bus
);

   logic [31:0] mem_result_q;
   logic [31:0] mem_b_q;
   logic [4:0]  mem_rw_q;
   logic        mem_regwr_q;
   logic        mem_memwr_q;
   logic        mem_memtoreg_q;

   logic [31:0] wb_result_q;
   logic [31:0] wb_dout_q;
   logic [4:0]  wb_rw_q;
   logic        wb_regwr_q;
   logic        wb_memtoreg_q;

   logic [31:0] ram [DEPTH];

   logic [AW-1:0] mem_index;
   logic          mem_misalign;
   logic          mem_store_ok;
   logic          mem_regwr_adj;
   logic [31:0]   mem_dout;

   // Upper address bits are dropped, so the address space wraps modulo DEPTH*4.
   assign mem_index     = mem_result_q[AW+1:2];
   assign mem_misalign  = (mem_memwr_q | mem_memtoreg_q) & (mem_result_q[1:0] != 2'b00);
   assign mem_store_ok  = mem_memwr_q & (mem_result_q[1:0] == 2'b00);
   assign mem_regwr_adj = mem_regwr_q & ~(mem_memtoreg_q & mem_misalign);
   assign mem_dout      = ram[mem_index];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_result_q   <= '0;
         mem_b_q        <= '0;
         mem_rw_q       <= '0;
         mem_regwr_q    <= 1'b0;
         mem_memwr_q    <= 1'b0;
         mem_memtoreg_q <= 1'b0;
      end else begin
         mem_result_q   <= bus.exe_result;
         mem_b_q        <= bus.exe_b;
         mem_rw_q       <= bus.exe_rw;
         mem_regwr_q    <= bus.exe_regwr;
         mem_memwr_q    <= bus.exe_memwr;
         mem_memtoreg_q <= bus.exe_memtoreg;
      end
   end

   // Memory contents survive reset; only the write is blocked while reset is high.
   always_ff @(posedge clk) begin
      if (!rst && mem_store_ok) begin
         ram[mem_index] <= mem_b_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_result_q   <= '0;
         wb_dout_q     <= '0;
         wb_rw_q       <= '0;
         wb_regwr_q    <= 1'b0;
         wb_memtoreg_q <= 1'b0;
      end else begin
         wb_result_q   <= mem_result_q;
         wb_dout_q     <= mem_dout;
         wb_rw_q       <= mem_rw_q;
         wb_regwr_q    <= mem_regwr_adj;
         wb_memtoreg_q <= mem_memtoreg_q;
      end
   end

   assign bus.mem_result   = mem_result_q;
   assign bus.mem_rw       = mem_rw_q;
   assign bus.mem_regwr    = mem_regwr_q;
   assign bus.mem_memtoreg = mem_memtoreg_q;
   assign bus.mem_misalign = mem_misalign;

   assign bus.wb_rw    = wb_rw_q;
   assign bus.wb_regwr = wb_regwr_q;
   assign bus.wb_busw  = wb_memtoreg_q ? wb_dout_q : wb_result_q;

endmodule
